mdu_seq: RTL and testbench
==========================

// Module: mdu_seq
// PURPOSE
//  Multi-cycle RV32M/RV64M multiply-divide unit, XLEN-parametrised, sitting beside the ALU in EX.
//  Operands are accepted on a valid/ready handshake. Multiplies use a MUL_LATENCY-deep pipeline.
//  Divides use a radix-2 restoring iterator. The result is returned as a one-cycle valid pulse.
//  Supports pipeline kill (flush) and single-cycle fast paths for the RISC-V divide corner cases.
// PARAMETERS
//  XLEN         32  operand/result width (32 or 64)
//  MUL_LATENCY  2   cycles from accept to valid_o for MUL/MULH/MULHSU/MULHU (>=1)
// PORTS
//  clk_i     in   1     clock, rising edge
//  rst_i     in   1     synchronous reset, active high
//  valid_i   in   1     request valid
//  ready_o   out  1     unit idle, may accept
//  op_i      in   3     funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
//  rs1_i     in   XLEN  operand 1 (dividend / multiplicand)
//  rs2_i     in   XLEN  operand 2 (divisor / multiplier)
//  kill_i    in   1     abort in-flight op, drop same-cycle request
//  valid_o   out  1     one-cycle result strobe
//  result_o  out  XLEN  result; holds last value between strobes
//  busy_o    out  1     operation in flight (!ready_o)
// BEHAVIOUR
//  Reset:
//   - state IDLE; ready_o=1, valid_o=0, busy_o=0, result_o=0, all internal regs cleared.
//   - rst_i mid-operation discards the op.
//  Accept:
//   - Occurs on valid_i & ready_o & !kill_i.
//   - op and operands are registered on that edge.
//   - ready_o=1 only in IDLE.
//  FSM states:
//   - IDLE: on accept, go to MUL if op[2]=0; otherwise FAST if a divide corner case applies, else DIV.
//   - MUL: count MUL_LATENCY-1 cycles, then DONE.
//   - DIV: 1 setup cycle (take magnitudes), XLEN shift/subtract cycles, 1 sign-fix cycle, then DONE.
//   - FAST: 1 cycle, then DONE.
//   - DONE: valid_o=1 and result_o updated for exactly one cycle, then IDLE.
//  Latency, counted in cycles after the accept edge (A):
//   - MUL ops: valid_o at A+MUL_LATENCY.
//   - Fast path: valid_o at A+1.
//   - Full divide: valid_o at A+XLEN+2.
//   - Next accept no earlier than the cycle after valid_o.
//  Arithmetic:
//   - 2*XLEN-bit product.
//   - MUL returns the low XLEN bits.
//   - MULH is signed x signed, high XLEN bits.
//   - MULHSU is signed rs1 x zero-extended rs2, high XLEN bits.
//   - MULHU is unsigned x unsigned, high XLEN bits.
//   - DIV truncates toward zero.
//   - REM takes the sign of the dividend.
//  Corner cases (fast path):
//   - Divisor 0: DIV/DIVU return all ones; REM/REMU return rs1.
//   - Signed overflow (rs1 = most-negative, rs2 = all ones) for DIV/REM: DIV returns rs1, REM returns 0.
//  Kill:
//   - kill_i in any non-IDLE state: next state IDLE, no valid_o, result_o unchanged.
//   - kill_i in the DONE cycle suppresses valid_o.
//   - kill_i with valid_i in IDLE: request not accepted.
//  Other inputs:
//   - op_i, rs1_i and rs2_i are don't-care after accept.
//   - valid_i while busy is ignored; the source must hold it until accepted.
// TESTING (XLEN=32, MUL_LATENCY=2)
//  1. MULH 0x80000000 x 0x80000000 -> result 0x40000000, valid_o at A+2; MUL same operands -> 0x00000000.
//  2. MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF; MULHU -> 0xFFFFFFFE; MUL -> 0x00000001.
//  3. DIV -7/2 -> 0xFFFFFFFD and REM -> 0xFFFFFFFF, both at A+34; DIVU 100/7 -> 14, REMU -> 2.
//  4. DIVU 5/0 -> 0xFFFFFFFF at A+1; REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0.
//  5. kill_i at A+10 of a DIV -> no valid_o, ready_o=1 at A+11; a MUL 3x4 accepted then -> 12 two cycles later.
//  6. rst_i at A+5 of a DIV -> next edge ready_o=1, valid_o=0, result_o=0; no strobe through A+40.

Source files
------------

// File: rtl/mdu_seq_if.sv
// Request/response bundle for the multiply-divide unit.
// master drives the request side, slave (the unit) drives ready/result.
interface mdu_seq_if #(
  parameter int XLEN = 32
);
  logic            valid_i;
  logic            ready_o;
  logic [2:0]      op_i;
  logic [XLEN-1:0] rs1_i;
  logic [XLEN-1:0] rs2_i;
  logic            kill_i;
  logic            valid_o;
  logic [XLEN-1:0] result_o;
  logic            busy_o;

  modport master (
    output valid_i, op_i, rs1_i, rs2_i, kill_i,
    input  ready_o, valid_o, result_o, busy_o
  );

  modport slave (
    input  valid_i, op_i, rs1_i, rs2_i, kill_i,
    output ready_o, valid_o, result_o, busy_o
  );
endinterface

// File: rtl/mdu_seq.sv
// Sequential RV32M/RV64M multiply-divide unit with kill and divide fast paths.
// Ports: clk_i, rst_i (sync, active high), bus (mdu_seq_if.slave).
module mdu_seq #(
  parameter int XLEN        = 32,
  parameter int MUL_LATENCY = 2
) (
  input  logic     clk_i,
  input  logic     rst_i,
  mdu_seq_if.slave bus
);
  localparam int CW = $clog2(XLEN + MUL_LATENCY + 2);
  localparam logic [CW-1:0] MUL_LAST = CW'(MUL_LATENCY - 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(XLEN + 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_MUL, S_DIV, S_FAST, S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] res_q, res_d;
  logic [XLEN-1:0] out_q, out_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            nq_q, nq_d;
  logic            nr_q, nr_d;

  logic accept;
  logic is_fast;
  logic ready;
  logic valid;
  logic busy;

  assign accept = bus.valid_i & (state_q == S_IDLE)
                & ~bus.kill_i;

  // Divide by zero, or signed most-negative / -1.
  assign is_fast = (bus.rs2_i == '0)
                 | (~bus.op_i[0]
                    & (bus.rs1_i == MIN_NEG)
                    & (bus.rs2_i == '1));

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (!bus.op_i[2])  state_d = S_MUL;
          else if (is_fast)  state_d = S_FAST;
          else               state_d = S_DIV;
        end
      end
      S_MUL:  if (cnt_q == MUL_LAST) state_d = S_DONE;
      S_DIV:  if (cnt_q == DIV_LAST) state_d = S_DONE;
      S_FAST: state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (bus.kill_i && state_q != S_IDLE)
      state_d = S_IDLE;
  end

  // FSM outputs
  always_comb begin
    ready = (state_q == S_IDLE);
    busy  = ~ready;
    valid = (state_q == S_DONE) & ~bus.kill_i;
  end

  assign bus.ready_o  = ready;
  assign bus.busy_o   = busy;
  assign bus.valid_o  = valid;
  // A killed DONE cycle must not expose the new result.
  assign bus.result_o = valid ? res_q : out_q;

  // Multiplier: sign-extend each operand by one bit
  // per op, then one 2*XLEN product covers all four.
  logic [XLEN:0]     ma, mb;
  logic [2*XLEN-1:0] pa, pb, prod;
  logic [XLEN-1:0]   mul_res;

  always_comb begin
    ma = {(op_q != 2'b11) & a_q[XLEN-1], a_q};
    mb = {(op_q == 2'b01) & b_q[XLEN-1], b_q};
    pa = {{(XLEN-1){ma[XLEN]}}, ma};
    pb = {{(XLEN-1){mb[XLEN]}}, mb};
    prod = pa * pb;
    if (op_q == 2'b00) mul_res = prod[XLEN-1:0];
    else               mul_res = prod[2*XLEN-1:XLEN];
  end

  logic [XLEN-1:0] fast_res;

  always_comb begin
    if (b_q == '0) fast_res = op_q[1] ? a_q : '1;
    else           fast_res = op_q[1] ? '0 : a_q;
  end

  // Restoring step: a_q shifts out dividend bits
  // and shifts in quotient bits.
  logic [XLEN:0] rsh, diff;
  logic          sgn;

  always_comb begin
    rsh  = {rem_q, a_q[XLEN-1]};
    diff = rsh - {1'b0, b_q};
    sgn  = ~op_q[0];
  end

  always_comb begin
    op_d  = op_q;
    a_d   = a_q;
    b_d   = b_q;
    rem_d = rem_q;
    res_d = res_q;
    cnt_d = cnt_q;
    nq_d  = nq_q;
    nr_d  = nr_q;
    out_d = valid ? res_q : out_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d  = bus.op_i[1:0];
          a_d   = bus.rs1_i;
          b_d   = bus.rs2_i;
          cnt_d = '0;
        end
      end
      S_MUL: begin
        cnt_d = cnt_q + CW'(1);
        res_d = mul_res;
      end
      S_FAST: res_d = fast_res;
      S_DIV: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == '0) begin
          nq_d  = sgn & (a_q[XLEN-1] ^ b_q[XLEN-1]);
          nr_d  = sgn & a_q[XLEN-1];
          a_d   = (sgn & a_q[XLEN-1]) ? -a_q : a_q;
          b_d   = (sgn & b_q[XLEN-1]) ? -b_q : b_q;
          rem_d = '0;
        end else if (cnt_q == DIV_LAST) begin
          if (op_q[1]) res_d = nr_q ? -rem_q : rem_q;
          else         res_d = nq_q ? -a_q : a_q;
        end else begin
          rem_d = diff[XLEN] ? rsh[XLEN-1:0]
                             : diff[XLEN-1:0];
          a_d   = {a_q[XLEN-2:0], ~diff[XLEN]};
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      rem_q <= '0;
      res_q <= '0;
      out_q <= '0;
      cnt_q <= '0;
      nq_q  <= 1'b0;
      nr_q  <= 1'b0;
    end else begin
      op_q  <= op_d;
      a_q   <= a_d;
      b_q   <= b_d;
      rem_q <= rem_d;
      res_q <= res_d;
      out_q <= out_d;
      cnt_q <= cnt_d;
      nq_q  <= nq_d;
      nr_q  <= nr_d;
    end
  end
endmodule

// File: tb/tb_mdu_seq.sv
// Directed + random scoreboard bench for mdu_seq.
// XLEN=32, MUL_LATENCY=2.
module tb_mdu_seq;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mdu_seq_if #(.XLEN(32)) bus ();

  mdu_seq #(
    .XLEN(32),
    .MUL_LATENCY(2)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus(bus)
  );

  typedef struct {
    logic [31:0] res;
    int          acc;
    int          lat;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          cyc = 0;
  int          n_assert = 0;
  int          n_fail = 0;
  int          strobes = 0;
  int          acc_cyc = 0;
  logic [31:0] last_res = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0 && bus.valid_o === 1'b1) begin
      strobes++;
      n_assert++;
      assert (sb.size() > 0) else begin
        n_fail++;
        $error("FAIL stray_strobe: observed %h expected none",
               bus.result_o);
      end
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        chk(mon_e.tag, bus.result_o, mon_e.res);
        chk({mon_e.tag, "_lat"}, 32'(cyc - mon_e.acc),
            32'(mon_e.lat));
        last_res = mon_e.res;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op,
                       input logic [31:0] a,
                       input logic [31:0] b);
    bus.op_i    = op;
    bus.rs1_i   = a;
    bus.rs2_i   = b;
    bus.valid_i = 1'b1;
    tick();
    acc_cyc     = cyc;
    bus.valid_i = 1'b0;
    bus.op_i    = 3'($urandom);
    bus.rs1_i   = $urandom;
    bus.rs2_i   = $urandom;
  endtask

  task automatic drain(input string tag);
    int i = 0;
    while (sb.size() != 0 && i < 80) begin
      tick();
      i++;
    end
    n_assert++;
    assert (sb.size() == 0) else begin
      n_fail++;
      $error("FAIL %s_timeout: observed %0d pending expected 0",
             tag, sb.size());
      sb.delete();
    end
  endtask

  task automatic run(input logic [2:0] op,
                     input logic [31:0] a,
                     input logic [31:0] b,
                     input logic [31:0] exp,
                     input int lat,
                     input string tag);
    exp_t e;
    chk({tag, "_ready"}, 32'(bus.ready_o), 32'd1);
    e.res = exp;
    e.acc = cyc + 1;
    e.lat = lat;
    e.tag = tag;
    sb.push_back(e);
    issue(op, a, b);
    chk({tag, "_busy"}, 32'(bus.busy_o), 32'd1);
    drain(tag);
  endtask

  function automatic logic [31:0] model(
      input logic [2:0] op,
      input logic [31:0] a,
      input logic [31:0] b);
    logic [63:0]        p;
    logic signed [31:0] sa, sd;
    logic               ovf;
    sa  = a;
    sd  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = '0;
    case (op)
      3'd0: p = {32'b0, a} * {32'b0, b};
      3'd1: p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
      3'd2: p = {{32{a[31]}}, a} * {32'b0, b};
      3'd3: p = {32'b0, a} * {32'b0, b};
      default: ;
    endcase
    case (op)
      3'd0: return p[31:0];
      3'd1, 3'd2, 3'd3: return p[63:32];
      3'd4: begin
        if (b == 0) return '1;
        if (ovf)    return a;
        return sa / sd;
      end
      3'd5: return (b == 0) ? '1 : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf)    return '0;
        return sa % sd;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int model_lat(
      input logic [2:0] op,
      input logic [31:0] a,
      input logic [31:0] b);
    logic ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    if (!op[2]) return 2;
    if (b == 0 || (!op[0] && ovf)) return 1;
    return 34;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    int          s0;

    rst         = 1'b1;
    bus.valid_i = 1'b0;
    bus.kill_i  = 1'b0;
    bus.op_i    = '0;
    bus.rs1_i   = '0;
    bus.rs2_i   = '0;
    repeat (3) tick();
    rst = 1'b0;
    #1;
    chk("rst_ready", 32'(bus.ready_o), 32'd1);
    chk("rst_valid", 32'(bus.valid_o), 32'd0);
    chk("rst_busy", 32'(bus.busy_o), 32'd0);
    chk("rst_result", bus.result_o, 32'd0);

    run(3'd1, 32'h8000_0000, 32'h8000_0000,
        32'h4000_0000, 2, "mulh_min");
    run(3'd0, 32'h8000_0000, 32'h8000_0000,
        32'h0000_0000, 2, "mul_min");
    run(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
        32'hFFFF_FFFF, 2, "mulhsu_ones");
    run(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
        32'hFFFF_FFFE, 2, "mulhu_ones");
    run(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
        32'h0000_0001, 2, "mul_ones");
    run(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
        32'h0000_0000, 2, "mulh_ones");

    run(3'd4, -32'sd7, 32'd2, 32'hFFFF_FFFD, 34, "div_m7_2");
    run(3'd6, -32'sd7, 32'd2, 32'hFFFF_FFFF, 34, "rem_m7_2");
    run(3'd5, 32'd100, 32'd7, 32'd14, 34, "divu_100_7");
    run(3'd7, 32'd100, 32'd7, 32'd2, 34, "remu_100_7");
    run(3'd4, 32'd7, -32'sd2, 32'hFFFF_FFFD, 34, "div_7_m2");
    run(3'd6, 32'd7, -32'sd2, 32'd1, 34, "rem_7_m2");

    run(3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, "divu_by0");
    run(3'd6, 32'd5, 32'd0, 32'd5, 1, "rem_by0");
    run(3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, "div_by0");
    run(3'd7, 32'd9, 32'd0, 32'd9, 1, "remu_by0");
    run(3'd4, 32'h8000_0000, 32'hFFFF_FFFF,
        32'h8000_0000, 1, "div_ovf");
    run(3'd6, 32'h8000_0000, 32'hFFFF_FFFF,
        32'h0000_0000, 1, "rem_ovf");
    run(3'd5, 32'h8000_0000, 32'hFFFF_FFFF,
        32'h0000_0000, 34, "divu_noovf");

    // Kill a divide mid-flight, then a MUL right after.
    issue(3'd4, 32'd1000, 32'd3);
    repeat (9) tick();
    bus.kill_i = 1'b1;
    tick();
    bus.kill_i = 1'b0;
    chk("kill_ready", 32'(bus.ready_o), 32'd1);
    chk("kill_valid", 32'(bus.valid_o), 32'd0);
    chk("kill_result", bus.result_o, last_res);
    run(3'd0, 32'd3, 32'd4, 32'd12, 2, "mul_after_kill");

    // Kill landing on the DONE cycle.
    issue(3'd0, 32'd5, 32'd6);
    tick();
    tick();
    bus.kill_i = 1'b1;
    #1;
    chk("kill_done_valid", 32'(bus.valid_o), 32'd0);
    chk("kill_done_result", bus.result_o, 32'd12);
    tick();
    bus.kill_i = 1'b0;
    #1;
    chk("kill_done_ready", 32'(bus.ready_o), 32'd1);

    // Request with kill in IDLE is dropped.
    bus.kill_i  = 1'b1;
    bus.valid_i = 1'b1;
    bus.op_i    = 3'd0;
    tick();
    bus.kill_i  = 1'b0;
    bus.valid_i = 1'b0;
    #1;
    chk("kill_idle_ready", 32'(bus.ready_o), 32'd1);
    chk("kill_idle_busy", 32'(bus.busy_o), 32'd0);

    for (int i = 0; i < 16; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      case ($urandom_range(0, 4))
        0: rb = '0;
        1: rb = 32'($urandom_range(1, 15));
        2: begin
          ra = 32'h8000_0000;
          rb = 32'hFFFF_FFFF;
        end
        default: rb = $urandom;
      endcase
      run(rop, ra, rb, model(rop, ra, rb),
          model_lat(rop, ra, rb),
          $sformatf("rnd%0d_op%0d", i, rop));
    end

    // Reset in the middle of a divide.
    issue(3'd5, 32'd1000, 32'd3);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    chk("midrst_ready", 32'(bus.ready_o), 32'd1);
    chk("midrst_valid", 32'(bus.valid_o), 32'd0);
    chk("midrst_result", bus.result_o, 32'd0);
    rst = 1'b0;
    s0  = strobes;
    repeat (36) tick();
    chk("midrst_nostrobe", 32'(strobes - s0), 32'd0);
    chk("midrst_hold", bus.result_o, 32'd0);
    run(3'd3, 32'd7, 32'd9, 32'd0, 2, "mulhu_post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end
endmodule
